// File: rtl/cpu_nic_if.sv
// CPU-side and router-side signal bundle for the cpu_nic block.
// The slave modport is the NIC's view; the master modport is the view of
// whatever drives the CPU port and the router port together.
interface cpu_nic_if #(
   parameter int DATA_WIDTH = 64
);
   // CPU access port
   logic                  nicEn;
   logic                  nicWrEn;
   logic [1:0]            addr;
   logic [0:DATA_WIDTH-1] d_in;
   logic [0:DATA_WIDTH-1] d_out;
   // Injection toward the router
   logic                  net_so;
   logic                  net_ro;
   logic [0:DATA_WIDTH-1] net_do;
   logic                  net_polarity;
   // Ejection from the router
   logic                  net_si;
   logic                  net_ri;
   logic [0:DATA_WIDTH-1] net_di;

   modport slave (
      input  nicEn, nicWrEn, addr, d_in, net_ro, net_polarity, net_si, net_di,
      output d_out, net_so, net_do, net_ri
   );

   modport master (
      output nicEn, nicWrEn, addr, d_in, net_ro, net_polarity, net_si, net_di,
      input  d_out, net_so, net_do, net_ri
   );
endinterface

// File: rtl/cpu_nic.sv
// Network interface controller: one single-entry packet buffer in each
// direction between the CPU NIC port and the local mesh router port.
// Handshake (both directions): a transfer happens on a rising edge where the
// sender's strobe (net_so / net_si) and the receiver's ready (net_ro / net_ri)
// are both high; a strobe without ready transfers nothing.
// Bit 0 of a packet is its virtual-channel bit (MSB in [0:N-1] ordering); it
// must match the router polarity before injection is allowed.
module cpu_nic #(
   parameter int DATA_WIDTH = 64
) (
   input  logic      clk,
   input  logic      reset,
   cpu_nic_if.slave  bus
);

   localparam logic [1:0] ADDR_OUT_BUF  = 2'b00;
   localparam logic [1:0] ADDR_OUT_STAT = 2'b01;
   localparam logic [1:0] ADDR_IN_BUF   = 2'b10;
   localparam logic [1:0] ADDR_IN_STAT  = 2'b11;

   logic [0:DATA_WIDTH-1] r_out_buf;
   logic                  r_out_full;
   logic [0:DATA_WIDTH-1] r_in_buf;
   logic                  r_in_full;
   logic [0:DATA_WIDTH-1] r_d_out;

   logic w_cpu_wr;
   logic w_cpu_rd;
   logic w_send;
   logic w_recv;

   assign w_cpu_wr = bus.nicEn & bus.nicWrEn;
   assign w_cpu_rd = bus.nicEn & ~bus.nicWrEn;
   // Injection only from registered state plus router ready/polarity
   assign w_send   = r_out_full & bus.net_ro & (r_out_buf[0] == bus.net_polarity);
   // A strobe while full is a router violation and is simply not accepted
   assign w_recv   = bus.net_si & ~r_in_full;

   assign bus.net_so = w_send;
   assign bus.net_do = r_out_buf;
   assign bus.net_ri = ~r_in_full;
   assign bus.d_out  = r_d_out;

   // Output buffer: CPU fills when empty, router drains; fullness judged at
   // cycle start so a write into a draining buffer is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_buf  <= '0;
         r_out_full <= 1'b0;
      end else if (w_send) begin
         r_out_full <= 1'b0;
      end else if (w_cpu_wr && (bus.addr == ADDR_OUT_BUF) && !r_out_full) begin
         r_out_buf  <= bus.d_in;
         r_out_full <= 1'b1;
      end
   end

   // Input buffer: router fills when empty, CPU read of the buffer empties it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_in_buf  <= '0;
         r_in_full <= 1'b0;
      end else if (w_recv) begin
         r_in_buf  <= bus.net_di;
         r_in_full <= 1'b1;
      end else if (w_cpu_rd && (bus.addr == ADDR_IN_BUF) && r_in_full) begin
         r_in_full <= 1'b0;
      end
   end

   // Registered CPU read data; holds when no read is issued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_d_out <= '0;
      end else if (w_cpu_rd) begin
         case (bus.addr)
            ADDR_OUT_STAT: r_d_out <= {{(DATA_WIDTH-1){1'b0}}, r_out_full};
            ADDR_IN_STAT:  r_d_out <= {{(DATA_WIDTH-1){1'b0}}, r_in_full};
            ADDR_IN_BUF:   r_d_out <= r_in_buf;
            default:       r_d_out <= '0;
         endcase
      end
   end

endmodule
